// File: rtl/modulo_empacotador_duzias_pkg.sv
// Shared line package for the dozen-bottle packer: state codes, box capacity
// and the completed-box counter limit.
package modulo_empacotador_duzias_pkg;

  typedef enum logic [1:0] {
    AGUARDA_CAIXA = 2'b00,
    ENCHENDO      = 2'b01,
    CHEIA         = 2'b10,
    SAIDA         = 2'b11
  } estado_t;

  localparam logic [3:0] CAPACIDADE_CAIXA = 4'd12;
  localparam logic [6:0] MAX_CAIXAS       = 7'd99;

  // Next value of a 0..MAX_CAIXAS counter; any out-of-range value recovers to 0.
  function automatic logic [6:0] proximo_mod100(input logic [6:0] valor);
    return (valor >= MAX_CAIXAS) ? 7'd0 : (valor + 7'd1);
  endfunction

endpackage

// File: rtl/modulo_empacotador_duzias_contador.sv
// Completed-box counter, 0..99 binary, wrapping to 0 after 99.
module modulo_contador_mod100
  import modulo_empacotador_duzias_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [6:0] q
);

  logic [6:0] r_q;

  // Box count register, advanced once per acknowledged full box.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q <= 7'd0;
    end else if (inc) begin
      r_q <= proximo_mod100(r_q);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/modulo_empacotador_duzias.sv
// Dozen-bottle packer: fills a box with 12 sealed bottles, hands it to the
// conveyor and flags lost bottles or boxes pulled away while filling.
module modulo_empacotador_duzias
  import modulo_empacotador_duzias_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       garrafa_vedada,
  input  logic       caixa_presente,
  input  logic       caixa_ack,
  output logic       ocupado,
  output logic       motor_caixa,
  output logic       caixa_cheia,
  output logic       alarme,
  output logic [3:0] cont_garrafas,
  output logic [6:0] cont_caixas,
  output logic [1:0] estado
);

  estado_t    r_estado;
  estado_t    w_estado_prox;
  logic [3:0] r_garrafas;
  logic [3:0] w_garrafas_prox;
  logic       r_alarme;
  logic       w_alarme_prox;
  logic       w_inc_caixa;

  // State, bottle count and sticky alarm registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_estado   <= AGUARDA_CAIXA;
      r_garrafas <= 4'd0;
      r_alarme   <= 1'b0;
    end else begin
      r_estado   <= w_estado_prox;
      r_garrafas <= w_garrafas_prox;
      r_alarme   <= w_alarme_prox;
    end
  end

  // Next-state logic; a paused line freezes everything and clears the alarm.
  always_comb begin
    w_estado_prox   = r_estado;
    w_garrafas_prox = r_garrafas;
    w_alarme_prox   = r_alarme;
    w_inc_caixa     = 1'b0;
    if (!enable) begin
      w_alarme_prox = 1'b0;
    end else begin
      case (r_estado)
        AGUARDA_CAIXA: begin
          w_alarme_prox = r_alarme | garrafa_vedada;
          w_estado_prox = caixa_presente ? ENCHENDO : AGUARDA_CAIXA;
        end
        ENCHENDO: begin
          // Box removal wins over a simultaneous bottle, which is then lost.
          if (!caixa_presente) begin
            w_alarme_prox   = 1'b1;
            w_garrafas_prox = 4'd0;
            w_estado_prox   = AGUARDA_CAIXA;
          end else if (garrafa_vedada) begin
            w_garrafas_prox = r_garrafas + 4'd1;
            w_estado_prox   = (r_garrafas == (CAPACIDADE_CAIXA - 4'd1)) ? CHEIA : ENCHENDO;
          end else begin
            w_estado_prox = ENCHENDO;
          end
        end
        CHEIA: begin
          w_alarme_prox = r_alarme | garrafa_vedada;
          if (caixa_ack) begin
            w_estado_prox = SAIDA;
            w_inc_caixa   = 1'b1;
          end else begin
            w_estado_prox = CHEIA;
          end
        end
        SAIDA: begin
          w_alarme_prox = r_alarme | garrafa_vedada;
          if (!caixa_presente) begin
            w_estado_prox   = AGUARDA_CAIXA;
            w_garrafas_prox = 4'd0;
          end else begin
            w_estado_prox = SAIDA;
          end
        end
        default: begin
          w_estado_prox = AGUARDA_CAIXA;
        end
      endcase
    end
  end

  // Moore output decode from the state register, gated by the run level.
  always_comb begin
    estado        = r_estado;
    cont_garrafas = r_garrafas;
    alarme        = r_alarme;
    caixa_cheia   = (r_estado == CHEIA);
    motor_caixa   = enable & ((r_estado == AGUARDA_CAIXA) | (r_estado == SAIDA));
    ocupado       = ~enable | (r_estado != ENCHENDO);
  end

  modulo_contador_mod100 u_contador_caixas (
    .clk (clk),
    .clr (clr),
    .inc (w_inc_caixa),
    .q   (cont_caixas)
  );

endmodule

// File: tb/tb_modulo_empacotador_duzias.sv
// Self-checking bench for the dozen-bottle packer: directed scenarios followed
// by a randomized run, all compared against a line-level behavioural model.
module tb_modulo_empacotador_duzias;

  logic       clk;
  logic       clr;
  logic       enable;
  logic       garrafa_vedada;
  logic       caixa_presente;
  logic       caixa_ack;
  logic       ocupado;
  logic       motor_caixa;
  logic       caixa_cheia;
  logic       alarme;
  logic [3:0] cont_garrafas;
  logic [6:0] cont_caixas;
  logic [1:0] estado;

  int checks;
  int errors;

  // Model of the line: phase named by its output code, plain integer counts.
  int m_fase;
  int m_garrafas;
  int m_caixas;
  int m_alarme;

  modulo_empacotador_duzias dut (
    .clk            (clk),
    .clr            (clr),
    .enable         (enable),
    .garrafa_vedada (garrafa_vedada),
    .caixa_presente (caixa_presente),
    .caixa_ack      (caixa_ack),
    .ocupado        (ocupado),
    .motor_caixa    (motor_caixa),
    .caixa_cheia    (caixa_cheia),
    .alarme         (alarme),
    .cont_garrafas  (cont_garrafas),
    .cont_caixas    (cont_caixas),
    .estado         (estado)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelo_reset();
    m_fase     = 0;
    m_garrafas = 0;
    m_caixas   = 0;
    m_alarme   = 0;
  endtask

  // What one rising edge does to the line, given the inputs seen before it.
  task automatic modelo_borda();
    if (!clr) begin
      modelo_reset();
    end else if (!enable) begin
      m_alarme = 0;
    end else begin
      case (m_fase)
        0: begin
          if (garrafa_vedada) m_alarme = 1;
          if (caixa_presente) m_fase = 1;
        end
        1: begin
          if (!caixa_presente) begin
            m_alarme = 1;
            m_garrafas = 0;
            m_fase = 0;
          end else if (garrafa_vedada) begin
            m_garrafas = m_garrafas + 1;
            if (m_garrafas == 12) m_fase = 2;
          end
        end
        2: begin
          if (garrafa_vedada) m_alarme = 1;
          if (caixa_ack) begin
            m_fase = 3;
            m_caixas = (m_caixas + 1) % 100;
          end
        end
        default: begin
          if (garrafa_vedada) m_alarme = 1;
          if (!caixa_presente) begin
            m_fase = 0;
            m_garrafas = 0;
          end
        end
      endcase
    end
  endtask

  task automatic confere(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    checks++;
    assert (obs === esp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, esp);
    end
  endtask

  task automatic confere_tudo(input string tag);
    logic exp_motor;
    logic exp_ocupado;
    exp_motor   = enable && (m_fase == 0 || m_fase == 3);
    exp_ocupado = !enable || (m_fase != 1);
    confere({tag, ".estado"},  {6'd0, estado},         8'(m_fase));
    confere({tag, ".garrafas"}, {4'd0, cont_garrafas}, 8'(m_garrafas));
    confere({tag, ".caixas"},  {1'b0, cont_caixas},    8'(m_caixas));
    confere({tag, ".alarme"},  {7'd0, alarme},         8'(m_alarme));
    confere({tag, ".cheia"},   {7'd0, caixa_cheia},    {7'd0, (m_fase == 2)});
    confere({tag, ".motor"},   {7'd0, motor_caixa},    {7'd0, exp_motor});
    confere({tag, ".ocupado"}, {7'd0, ocupado},        {7'd0, exp_ocupado});
  endtask

  // One clock: edge, model update, then outputs checked 1 time unit later.
  task automatic ciclo(input string tag);
    @(posedge clk);
    modelo_borda();
    #1;
    confere_tudo(tag);
  endtask

  task automatic entradas(input logic en, input logic g, input logic p, input logic a);
    enable = en;
    garrafa_vedada = g;
    caixa_presente = p;
    caixa_ack = a;
  endtask

  task automatic caixa_completa(input string tag);
    entradas(1'b1, 1'b0, 1'b1, 1'b0);
    ciclo({tag, ".chega"});
    for (int i = 0; i < 12; i++) begin
      entradas(1'b1, 1'b1, 1'b1, 1'b0);
      ciclo({tag, ".garrafa"});
    end
    entradas(1'b1, 1'b0, 1'b1, 1'b1);
    ciclo({tag, ".ack"});
    entradas(1'b1, 1'b0, 1'b0, 1'b0);
    ciclo({tag, ".sai"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b0;
    entradas(1'b1, 1'b0, 1'b0, 1'b0);
    modelo_reset();

    #2;
    confere_tudo("reset");
    ciclo("reset_borda");
    clr = 1'b1;

    // Twelve bottles into one box; count visible after each pulse.
    entradas(1'b1, 1'b0, 1'b1, 1'b0);
    ciclo("chega");
    confere("chega.estado_enchendo", {6'd0, estado}, 8'd1);
    for (int i = 1; i <= 12; i++) begin
      entradas(1'b1, 1'b1, 1'b1, 1'b0);
      ciclo("enche");
      confere("enche.contagem", {4'd0, cont_garrafas}, 8'(i));
    end
    entradas(1'b1, 1'b0, 1'b1, 1'b0);
    ciclo("cheia_espera");
    confere("cheia.estado", {6'd0, estado}, 8'd2);
    confere("cheia.sinal", {7'd0, caixa_cheia}, 8'd1);

    entradas(1'b1, 1'b0, 1'b1, 1'b1);
    ciclo("ack");
    confere("ack.estado_saida", {6'd0, estado}, 8'd3);
    confere("ack.caixas", {1'b0, cont_caixas}, 8'd1);
    entradas(1'b1, 1'b0, 1'b0, 1'b0);
    ciclo("saida");
    confere("saida.estado", {6'd0, estado}, 8'd0);
    confere("saida.garrafas", {4'd0, cont_garrafas}, 8'd0);
    confere("saida.motor", {7'd0, motor_caixa}, 8'd1);

    // Stray bottle while waiting for a box, then a one-cycle pause.
    entradas(1'b1, 1'b1, 1'b0, 1'b1);
    ciclo("perdida");
    confere("perdida.alarme", {7'd0, alarme}, 8'd1);
    entradas(1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    confere_tudo("pausa_comb");
    ciclo("pausa");
    confere("pausa.alarme", {7'd0, alarme}, 8'd0);

    // Five bottles, then the box is pulled away.
    entradas(1'b1, 1'b0, 1'b1, 1'b0);
    ciclo("parcial_chega");
    for (int i = 0; i < 5; i++) begin
      entradas(1'b1, 1'b1, 1'b1, 1'b0);
      ciclo("parcial");
    end
    entradas(1'b1, 1'b1, 1'b0, 1'b0);
    ciclo("retirada");
    confere("retirada.alarme", {7'd0, alarme}, 8'd1);
    confere("retirada.garrafas", {4'd0, cont_garrafas}, 8'd0);
    entradas(1'b0, 1'b0, 1'b0, 1'b0);
    ciclo("limpa_alarme");

    // Run the box counter up to 99 and across the wrap.
    for (int b = 1; b < 99; b++) begin
      caixa_completa("preset");
    end
    confere("preset.99", {1'b0, cont_caixas}, 8'd99);
    caixa_completa("wrap");
    confere("wrap.zero", {1'b0, cont_caixas}, 8'd0);

    // Randomized line activity.
    for (int i = 0; i < 3000; i++) begin
      logic p_novo;
      p_novo = caixa_presente;
      if ($urandom_range(0, 99) < 8) p_novo = ~caixa_presente;
      entradas(($urandom_range(0, 99) < 93) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
               p_novo,
               ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0);
      ciclo("aleatorio");
    end

    // Asynchronous reset arriving between edges while a box is full.
    entradas(1'b1, 1'b0, 1'b0, 1'b0);
    ciclo("pre_reset_a");
    ciclo("pre_reset_b");
    caixa_completa("pre_reset_box");
    entradas(1'b1, 1'b0, 1'b1, 1'b0);
    ciclo("cheia2_chega");
    for (int i = 0; i < 12; i++) begin
      entradas(1'b1, 1'b1, 1'b1, 1'b0);
      ciclo("cheia2");
    end
    entradas(1'b1, 1'b0, 1'b1, 1'b0);
    confere("cheia2.estado", {6'd0, estado}, 8'd2);
    #2;
    clr = 1'b0;
    modelo_reset();
    #1;
    confere_tudo("reset_async");
    confere("reset_async.estado", {6'd0, estado}, 8'd0);
    confere("reset_async.cheia", {7'd0, caixa_cheia}, 8'd0);
    ciclo("reset_async_borda");
    #2;
    clr = 1'b1;
    entradas(1'b1, 1'b0, 1'b1, 1'b0);
    ciclo("pos_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
